reg_file_loader: RTL
====================

# reg_file_loader

Write-side front end for the 4×512-bit operand register file. Accepts a narrow valid/ready word stream, assembles either one 512-bit register image or one 1024-bit register-pair image, and issues a single-cycle write command on the register file's write port (`write`, `write_address`, `write_data`). Sits between the memory/DMA stream and the register file. The register file gives `write_address[2]` priority over `write`, so this block owns the bit-2 discipline.

## Interface
- `WORD_W`, 32: stream word width; must divide `REG_W`.
- `REG_W`, 512: register width; `write_data` is 2·`REG_W`.
- Clock: `clk`, single domain. Reset: `rst`, asynchronous, active-high.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  load request; sampled only in IDLE.
- `dest`  in  3  target: `dest[2]`=0 → register `dest[1:0]`; `dest[2]`=1 → pair {3,2} (`dest[1:0]` ignored).
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  block accepts word; a word transfers when `in_valid`&&`in_ready`.
- `in_data`  in  `WORD_W`  stream word.
- `busy`  out  1  high in FILL and COMMIT.
- `done`  out  1  one-cycle pulse, coincident with the write cycle.
- `write`  out  1  register-file write strobe.
- `write_address`  out  3  register-file address.
- `write_data`  out  2·`REG_W`  assembled image.
- `abort`  in  1  present only with `REG_LOADER_ABORT_EN`.

## Operation
- N = `REG_W`/`WORD_W` (16) for single, 2N (32) for pair.
- States: IDLE, FILL, COMMIT.
- IDLE: `in_ready`=0. On `start`: capture `dest`, clear word counter, clear whole buffer to zero, go to FILL.
- FILL: `in_ready`=1. Each transfer: word k written to buffer bits [k·`WORD_W` +: `WORD_W`] (word 0 = LSBs); counter increments. `in_valid`=0 cycles stall, no state change. Transfer of word N−1 (2N−1 for pair) → COMMIT.
- COMMIT (exactly one cycle): `done`=1, `in_ready`=0.
  - Single: `write`=1, `write_address`={0,`dest[1:0]`}, `write_data`[2·`REG_W`−1:`REG_W`]=0.
  - Pair: `write`=1, `write_address`=3'b100, `write_data`={reg3, reg2} = full buffer (words N..2N−1 land in register 3).
  - Next state IDLE.
- Outside COMMIT: `write`=0 and `write_address`=3'b000 unconditionally (bit 2 must never be high, otherwise the register file writes the pair).
- `write_data` holds the buffer contents at all times; meaningful only during COMMIT.
- `start` in FILL/COMMIT: ignored, not queued.
- Counter width: clog2(2N); wraps only via the state change, never overflows.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `write`=0, `write_address`=0, `write_data`=0, state IDLE, counter 0.
- `start` high at edge t → FILL from t+1 (`in_ready`=1 in cycle t+1).
- With continuous `in_valid`, last word transfers at edge t+N; COMMIT in cycle t+N+1; IDLE at t+N+2. A new `start` is accepted at edge t+N+2 earliest.
- Register file contents update at the end of the COMMIT cycle.
- `rst` asserted mid-FILL or mid-COMMIT: immediate return to reset values, no write issued, partial buffer discarded.
- All outputs are registered or decoded from state only; no combinational path from `in_valid` to `in_ready`.

## Configuration
- `REG_LOADER_ABORT_EN` defined: `abort` port exists. `abort`=1 in FILL → IDLE at next edge, no write, no `done`, buffer zeroed; the word presented in the same cycle is not accepted (`in_ready` forced 0). `abort` in IDLE/COMMIT has no effect.
- Not defined: no `abort` port; FILL exits only on the last word or `rst`.

## Test plan
- Single load: `start`, `dest`=3'b001, words 0x1000+k (k=0..15) back-to-back → COMMIT 17 cycles after `start` edge, `write`=1, `write_address`=3'b001, word k at bits [32k+:32], upper 512 bits zero, `done` 1 cycle.
- Pair load: `dest`=3'b110, words 0xA000+k (k=0..31) → `write_address`=3'b100, `write_data`[1023:992]=0xA01F, [31:0]=0xA000; `write_address[2]`=0 in every other cycle.
- Backpressure: `in_valid` toggled 1/0 each cycle for a single load → COMMIT 33 cycles after `start`, same image as the back-to-back case.
- Busy start: `start` with `dest`=3'b011 pulsed mid-FILL of a `dest`=3'b000 load → single write to address 0 only, one `done`.
- Reset: `rst` after word 7 → all outputs zero, no `write`; subsequent full load to 3'b010 writes correctly with words 0..7 from the new stream.
- Abort (`REG_LOADER_ABORT_EN`): `abort` after word 5 → IDLE next cycle, no `write`/`done`; next `start` accepted in the following cycle.

Source files
------------

// File: rtl/reg_file_loader_if.sv
// Stream-in / register-file-write bundle for reg_file_loader.
// slave modport: the loader; master modport: the stream source and register file side.
interface reg_file_loader_if #(
   parameter int WORD_W = 32,
   parameter int REG_W  = 512
);
   logic                 start;
   logic [2:0]           dest;
   logic                 in_valid;
   logic                 in_ready;
   logic [WORD_W-1:0]    in_data;
   logic                 busy;
   logic                 done;
   logic                 write;
   logic [2:0]           write_address;
   logic [2*REG_W-1:0]   write_data;

   modport slave (
      input  start, dest, in_valid, in_data,
      output in_ready, busy, done, write, write_address, write_data
   );

   modport master (
      output start, dest, in_valid, in_data,
      input  in_ready, busy, done, write, write_address, write_data
   );
endinterface

// File: rtl/reg_file_loader.sv
// Write-side front end of the 4x512-bit operand register file.
// Assembles WORD_W-bit stream words into a single-register or register-pair
// image and issues one write cycle. Bit 2 of write_address selects a pair
// write in the register file, so it is only ever driven high during COMMIT.
// Optional feature macro: REG_LOADER_ABORT_EN (adds the abort input).
module reg_file_loader #(
   parameter int WORD_W = 32,
   parameter int REG_W  = 512
) (
   input  logic               clk,
   input  logic               rst,
`ifdef REG_LOADER_ABORT_EN
   input  logic               abort,
`endif
   reg_file_loader_if.slave   bus
);
   localparam int N     = REG_W / WORD_W;
   localparam int CNT_W = $clog2(2 * N);
   localparam logic [CNT_W-1:0] LAST_SINGLE = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] LAST_PAIR   = CNT_W'(2 * N - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 r_pair;
   logic [1:0]           r_sel;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*REG_W-1:0]   r_buf;

   logic                 w_abort;
   logic                 w_ready;
   logic                 w_xfer;
   logic                 w_last;

`ifdef REG_LOADER_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_xfer  = w_ready && bus.in_valid;
   assign w_last  = r_pair ? (r_cnt == LAST_PAIR) : (r_cnt == LAST_SINGLE);

   assign bus.in_ready   = w_ready;
   assign bus.write_data = r_buf;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next state and state-decoded outputs; write_address stays 0 outside COMMIT.
   always_comb begin
      w_next            = r_state;
      w_ready           = 1'b0;
      bus.busy          = 1'b0;
      bus.done          = 1'b0;
      bus.write         = 1'b0;
      bus.write_address = 3'b000;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_next = S_FILL;
         end
         S_FILL: begin
            bus.busy = 1'b1;
            if (w_abort) begin
               w_next = S_IDLE;
            end else begin
               w_ready = 1'b1;
               if (bus.in_valid && w_last) w_next = S_COMMIT;
            end
         end
         S_COMMIT: begin
            bus.busy          = 1'b1;
            bus.done          = 1'b1;
            bus.write         = 1'b1;
            bus.write_address = r_pair ? 3'b100 : {1'b0, r_sel};
            w_next            = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Target capture, word counter and image buffer; buffer is cleared on start so
   // a single-register load always leaves the upper half zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pair <= 1'b0;
         r_sel  <= 2'b00;
         r_cnt  <= '0;
         r_buf  <= '0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_pair <= bus.dest[2];
         r_sel  <= bus.dest[1:0];
         r_cnt  <= '0;
         r_buf  <= '0;
      end else if (r_state == S_FILL && w_abort) begin
         r_cnt  <= '0;
         r_buf  <= '0;
      end else if (w_xfer) begin
         for (int k = 0; k < 2 * N; k++) begin
            if (r_cnt == CNT_W'(k)) r_buf[k*WORD_W +: WORD_W] <= bus.in_data;
         end
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end
endmodule
